csdf_rr: RTL

Parametrised cyclo-static dataflow accumulate actor: each of FLUX independent data fluxes gathers one token per port per firing, sums them into a per-flux accumulator, and emits one tagged result after a phase-dependent number of firings. Successor to the fixed-priority CSDF actor. Adds per-phase operation counts (true cyclo-static behaviour), round-robin flux arbitration, and optional saturating arithmetic. Sits between the per-flux input FIFO bank and a single shared output FIFO in the multi-dataflow actor network.

---
 rtl/csdf_rr.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/csdf_rr.sv
// Cyclo-static dataflow accumulate actor: each flux sums PORTS tokens per firing and
// emits one tagged result per phase, with round-robin arbitration between fluxes.
module csdf_rr #(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX = 2,
    parameter int PORTS = 2,
    parameter int PHASES = 2,
    parameter int CNT_WIDTH = 4,
    parameter logic [PHASES*CNT_WIDTH-1:0] OPS_PER_PHASE = {4'd3, 4'd2},
    parameter bit SAT = 1'b0,
    localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [FLUX*PORTS*(DATA_WIDTH+TAG_WIDTH)-1:0] read_port_dout_i,
    input  logic [FLUX*PORTS-1:0]                        read_port_empty_i,
    output logic [FLUX*PORTS-1:0]                        read_port_read_o,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0]              write_port_din_o,
    output logic                                         write_port_write_o,
    input  logic                                         write_port_full_i
);
    localparam int PH_W  = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int TOK_W = DATA_WIDTH + TAG_WIDTH;

    logic [DATA_WIDTH-1:0] acc_q  [FLUX];
    logic [CNT_WIDTH-1:0]  cnt_q  [FLUX];
    logic [PH_W-1:0]       ph_q   [FLUX];
    logic [FLUX-1:0]       pend_q;
    logic [TAG_WIDTH-1:0]  rr_q;

    logic [DATA_WIDTH-1:0] acc_d;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [PH_W-1:0]       ph_d;
    logic                  pend_d;

    logic [FLUX-1:0]              elig_s;
    logic                         grant_s;
    logic [TAG_WIDTH-1:0]         gnt_s;
    logic [DATA_WIDTH:0]          sum_s;
    logic [FLUX*PORTS-1:0]        rd_s;
    logic                         wr_s;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] din_s;

    // A zero count field still means one firing per phase.
    function automatic logic [CNT_WIDTH-1:0] phase_count(input logic [PH_W-1:0] ph);
        logic [CNT_WIDTH-1:0] field;
        field = OPS_PER_PHASE[int'(ph)*CNT_WIDTH +: CNT_WIDTH];
        return (field == '0) ? CNT_WIDTH'(1) : field;
    endfunction

    function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] ph);
        return (ph == PH_W'(PHASES - 1)) ? PH_W'(0) : ph + PH_W'(1);
    endfunction

    // Eligibility and round-robin search starting after the last grant
    always_comb begin
        grant_s = 1'b0;
        gnt_s   = '0;
        for (int f = 0; f < FLUX; f++) begin
            elig_s[f] = pend_q[f] ? ~write_port_full_i
                                  : ~|read_port_empty_i[f*PORTS +: PORTS];
        end
        for (int k = 1; k <= FLUX; k++) begin
            if (!grant_s && elig_s[(int'(rr_q) + k) % FLUX]) begin
                grant_s = 1'b1;
                gnt_s   = TAG_WIDTH'((int'(rr_q) + k) % FLUX);
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Firing datapath: sum, case selection, outputs and granted flux next state
    always_comb begin
        rd_s   = '0;
        wr_s   = 1'b0;
        din_s  = {rr_q, acc_q[rr_q]};
        acc_d  = acc_q[gnt_s];
        cnt_d  = cnt_q[gnt_s];
        ph_d   = ph_q[gnt_s];
        pend_d = pend_q[gnt_s];
        sum_s  = {1'b0, acc_q[gnt_s]};
        for (int p = 0; p < PORTS; p++) begin
            sum_s = {1'b0, sum_s[DATA_WIDTH-1:0]}
                  + {1'b0, read_port_dout_i[(int'(gnt_s)*PORTS + p)*TOK_W +: DATA_WIDTH]};
            if (SAT && sum_s[DATA_WIDTH]) begin
                sum_s = {1'b0, {DATA_WIDTH{1'b1}}};
            end else begin
                sum_s[DATA_WIDTH] = 1'b0;
            end
        end
        if (!grant_s) begin
            wr_s = 1'b0;
        end else if (pend_q[gnt_s]) begin
            wr_s   = 1'b1;
            din_s  = {gnt_s, acc_q[gnt_s]};
            pend_d = 1'b0;
            acc_d  = '0;
            ph_d   = next_phase(ph_q[gnt_s]);
            cnt_d  = phase_count(ph_d) - CNT_WIDTH'(1);
        end else begin
            rd_s[int'(gnt_s)*PORTS +: PORTS] = {PORTS{1'b1}};
            if (cnt_q[gnt_s] != '0) begin
                acc_d = sum_s[DATA_WIDTH-1:0];
                cnt_d = cnt_q[gnt_s] - CNT_WIDTH'(1);
            end else if (!write_port_full_i) begin
                wr_s  = 1'b1;
                din_s = {gnt_s, sum_s[DATA_WIDTH-1:0]};
                acc_d = '0;
                ph_d  = next_phase(ph_q[gnt_s]);
                cnt_d = phase_count(ph_d) - CNT_WIDTH'(1);
            end else begin
                acc_d  = sum_s[DATA_WIDTH-1:0];
                pend_d = 1'b1;
            end
        end
    end

    // Outputs are forced quiet for as long as reset is held
    assign read_port_read_o   = rst ? '0 : rd_s;
    assign write_port_write_o = rst ? 1'b0 : wr_s;
    assign write_port_din_o   = rst ? '0 : din_s;

    // Per-flux state and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= TAG_WIDTH'(FLUX - 1);
            pend_q <= '0;
            for (int f = 0; f < FLUX; f++) begin
                acc_q[f] <= '0;
                ph_q[f]  <= '0;
                cnt_q[f] <= phase_count(PH_W'(0)) - CNT_WIDTH'(1);
            end
        end else if (grant_s) begin
            rr_q          <= gnt_s;
            acc_q[gnt_s]  <= acc_d;
            cnt_q[gnt_s]  <= cnt_d;
            ph_q[gnt_s]   <= ph_d;
            pend_q[gnt_s] <= pend_d;
        end
    end
endmodule
